// File: rtl/y_rr_arb4_pkg.sv
// Shared state encodings, pointer reset value and the rotate-then-priority pick
// used by the lab datapath blocks.
package y_rr_arb4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [1:0] LAST_RST = 2'd3;

    // Rotate req so that requester last+1 lands in bit 0, take the lowest set bit,
    // then undo the rotation. Result is only meaningful when |req.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [7:0] dbl;
        logic [2:0] sh;
        logic [7:0] r8;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {req, req};
        sh  = {1'b0, last} + 3'd1;
        r8  = dbl >> sh;
        rot = r8[3:0];
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else             off = 2'd3;
        return last + 2'd1 + off;
    endfunction

endpackage

// File: rtl/yMux4to1.sv
// Parameterized 4:1 word multiplexer.
module yMux4to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        case (s)
            2'd0:    z = a0;
            2'd1:    z = a1;
            2'd2:    z = a2;
            default: z = a3;
        endcase
    end

endmodule

// File: rtl/y_rr_arb4.sv
// Four-requester round-robin arbiter feeding a single-entry output register
// with valid/ready handshake.
module y_rr_arb4
    import y_rr_arb4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [1:0]       last_q;
    logic [1:0]       winner;
    logic             can_load;
    logic             capture;
    logic [WIDTH-1:0] mux_out;

    assign can_load = (state_q == IDLE) || out_ready;
    assign winner   = rr_pick(req, last_q);
    // Reset suppresses the strobe so a grant never fires on a cycle that is discarded.
    assign capture  = !reset && can_load && (|req);

    yMux4to1 #(.WIDTH(WIDTH)) u_mux (
        .a0 (d0),
        .a1 (d1),
        .a2 (d2),
        .a3 (d3),
        .s  (winner),
        .z  (mux_out)
    );

    always_comb begin
        gnt = '0;
        if (capture) gnt[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (can_load) state_d = (|req) ? HOLD : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            sel      <= 2'd0;
            last_q   <= LAST_RST;
        end else if (capture) begin
            out_data <= mux_out;
            sel      <= winner;
            last_q   <= winner;
        end
    end

    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_y_rr_arb4.sv
// Scoreboard bench for y_rr_arb4: stimulus queues per-cycle expectations, a
// negedge monitor pops and compares them against the DUT.
module tb_y_rr_arb4;

    typedef struct {
        logic [3:0]  gnt;
        logic        valid;
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [31:0] d [4];
    logic        out_ready = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    // Reference model state
    logic        m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_sel;
    logic [1:0]  m_last;

    int wait_cnt [4];

    always #5 clk = ~clk;

    y_rr_arb4 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic exp_t model_eval();
        exp_t e;
        e.gnt   = 4'b0;
        e.valid = m_valid;
        e.data  = m_data;
        e.sel   = m_sel;
        if (!reset && (!m_valid || out_ready)) begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (int'(m_last) + k) % 4;
                if (req[idx] && e.gnt == 4'b0) e.gnt[idx] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic model_update(input logic [3:0] g);
        if (reset) begin
            m_valid = 1'b0; m_data = 32'h0; m_sel = 2'd0; m_last = 2'd3;
        end else if (g != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (g[i]) begin
                    m_data = d[i]; m_sel = 2'(i); m_last = 2'(i);
                end
            m_valid = 1'b1;
        end else if (!m_valid || out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Directed step with hand-computed expectations for this cycle.
    task automatic step(input logic r, input logic [3:0] rq, input logic rd,
                        input logic [3:0] eg, input logic ev, input logic [31:0] ed,
                        input logic [1:0] es);
        exp_t e, m;
        reset = r; req = rq; out_ready = rd;
        e.gnt = eg; e.valid = ev; e.data = ed; e.sel = es;
        sb.push_back(e);
        m = model_eval();
        model_update(m.gnt);
        @(posedge clk); #1;
    endtask

    task automatic rand_step();
        exp_t e;
        reset = ($urandom_range(0, 49) == 0);
        req = 4'($urandom_range(0, 15));
        out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        e = model_eval();
        sb.push_back(e);
        model_update(e.gnt);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (gnt !== e.gnt) begin
                bad++;
                $display("FAIL gnt: got %b want %b (req=%b rdy=%b rst=%b)", gnt, e.gnt, req, out_ready, reset);
            end
            total++;
            if (out_valid !== e.valid) begin
                bad++;
                $display("FAIL out_valid: got %b want %b", out_valid, e.valid);
            end
            total++;
            if (out_data !== e.data) begin
                bad++;
                $display("FAIL out_data: got %h want %h (sel=%0d)", out_data, e.data, sel);
            end
            total++;
            if (sel !== e.sel) begin
                bad++;
                $display("FAIL sel: got %0d want %0d", sel, e.sel);
            end
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL gnt_onehot: got %b want at most one bit", gnt);
            end
            for (int i = 0; i < 4; i++) begin
                if (reset || !req[i] || gnt[i]) wait_cnt[i] = 0;
                else if (gnt != 4'b0) wait_cnt[i]++;
                if (wait_cnt[i] > 3) begin
                    total++;
                    bad++;
                    $display("FAIL fairness: req %0d waited %0d captures want <=3", i, wait_cnt[i]);
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    localparam logic [31:0] D0 = 32'hA0A0_0000, D1 = 32'hB1B1_0001,
                            D2 = 32'hC2C2_0002, D3 = 32'hD3D3_0003;

    initial begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        d[0] = D0; d[1] = D1; d[2] = D2; d[3] = D3;
        m_valid = 1'b0; m_data = 32'h0; m_sel = 2'd0; m_last = 2'd3;
        @(posedge clk); #1;
        // reset state
        step(1, 4'b1111, 1, 4'b0000, 0, 32'h0, 2'd0);
        // full rotation
        step(0, 4'b1111, 1, 4'b0001, 0, 32'h0, 2'd0);
        step(0, 4'b1111, 1, 4'b0010, 1, D0, 2'd0);
        step(0, 4'b1111, 1, 4'b0100, 1, D1, 2'd1);
        step(0, 4'b1111, 1, 4'b1000, 1, D2, 2'd2);
        step(0, 4'b1111, 1, 4'b0001, 1, D3, 2'd3);
        step(0, 4'b1111, 1, 4'b0010, 1, D0, 2'd0);
        step(0, 4'b1111, 1, 4'b0100, 1, D1, 2'd1);
        step(0, 4'b1111, 1, 4'b1000, 1, D2, 2'd2);
        // single requester
        d[2] = 32'hDEADBEEF;
        step(0, 4'b0100, 1, 4'b0100, 1, D3, 2'd3);
        step(0, 4'b0100, 1, 4'b0100, 1, 32'hDEADBEEF, 2'd2);
        step(0, 4'b0100, 1, 4'b0100, 1, 32'hDEADBEEF, 2'd2);
        // backpressure
        d[1] = 32'h0000_1234;
        step(0, 4'b0010, 1, 4'b0010, 1, 32'hDEADBEEF, 2'd2);
        for (int i = 0; i < 5; i++)
            step(0, 4'b1111, 0, 4'b0000, 1, 32'h0000_1234, 2'd1);
        step(0, 4'b1111, 1, 4'b0100, 1, 32'h0000_1234, 2'd1);
        // drain to IDLE, then single capture and drain
        step(0, 4'b0000, 1, 4'b0000, 1, 32'hDEADBEEF, 2'd2);
        step(0, 4'b0001, 1, 4'b0001, 0, 32'hDEADBEEF, 2'd2);
        step(0, 4'b0000, 1, 4'b0000, 1, D0, 2'd0);
        step(0, 4'b0000, 0, 4'b0000, 0, D0, 2'd0);
        // reset in HOLD
        step(0, 4'b0100, 1, 4'b0100, 0, D0, 2'd0);
        step(1, 4'b1111, 1, 4'b0000, 1, 32'hDEADBEEF, 2'd2);
        step(0, 4'b1010, 1, 4'b0010, 0, 32'h0, 2'd0);
        step(0, 4'b0000, 1, 4'b0000, 1, 32'h0000_1234, 2'd1);
        // random against the model
        for (int n = 0; n < 500; n++) rand_step();
        reset = 1'b0; req = 4'b0; out_ready = 1'b0;
        for (int n = 0; n < 4 && sb.size() > 0; n++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_scoreboard: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y_rr_arb4.md
Y_RR_ARB4 -- requirements
Module: y_rr_arb4

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of every requester port and the output port.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock, reset synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i has a word on d<i>.
REQ-005 SHALL have ports d0, d1, d2, d3, input, WIDTH bits each: requester data, held stable while req[i] is high.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot acceptance strobe; gnt[i] high for exactly the cycle in which d<i> is captured.
REQ-007 SHALL have port sel, output, 2 bits: mux select of the most recent capture.
REQ-008 SHALL have port out_data, output, WIDTH bits: registered captured word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data in any cycle where out_valid and out_ready are both high.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 SHALL define can_load = (state==IDLE) or (state==HOLD and out_ready).
REQ-013 SHALL capture a word when can_load and |req: winner = first requester with req high, searching last+1, last+2, last+3, last (mod 4).
REQ-014 SHALL, on capture: load out_data with d<winner>, set sel=winner and last=winner, pulse gnt[winner], and enter or stay in HOLD.
REQ-015 SHALL, when can_load and req==0: keep gnt=0, go to IDLE (or stay there), and hold out_data, sel and last.
REQ-016 SHALL, in HOLD with out_ready low: hold out_data, out_valid, sel and last, and keep gnt=0, regardless of req.
REQ-017 SHALL drive gnt combinationally from current state, req, out_ready and last, with at most one bit set.
REQ-018 SHALL give one-cycle latency: a word captured at edge N appears on out_data with out_valid=1 after edge N.
REQ-019 SHALL sustain back-to-back transfers (one per cycle) while out_ready stays high and req is non-zero.
REQ-020 SHALL wrap the pointer so that winner 3 is followed by a search starting at 0.
REQ-021 SHALL grant any continuously asserted req[i] within 4 captures.
REQ-022 SHALL, when only one req bit is set, grant it on every capture regardless of last.
REQ-023 SHALL treat req changes as taking effect only at the next capture decision; a req dropped in HOLD has no effect until can_load.

Reset
REQ-024 SHALL, when reset is high at a rising edge, set state=IDLE, out_valid=0, out_data=0, sel=0, last=3 (requester 0 wins first).
REQ-025 SHALL force gnt=0 in any cycle where reset is high, including mid-transfer; a word pending in HOLD is discarded.
REQ-026 SHALL give reset priority over capture and over out_ready.

Structure
REQ-027 SHALL keep the state encodings (IDLE=0, HOLD=1) and the pointer reset value (3) in a shared include file for the lab datapath blocks.
REQ-028 SHALL route the captured word through one instance of the existing parameterized yMux4to1 (WIDTH bits), with selects from the winner index; no other sub-modules.
REQ-029 SHALL implement the priority search as a rotate-then-fixed-priority of req by last+1.

Verification
REQ-030 SHALL check: reset; req=4'b1111, out_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with out_data matching d0,d1,d2,d3,... one cycle later.
REQ-031 SHALL check: req=4'b0100, d2=32'hDEADBEEF, out_ready=1 -> gnt=0100 every cycle, out_data=32'hDEADBEEF, sel=2.
REQ-032 SHALL check backpressure: capture d1=32'h0000_1234, then out_ready=0 for 5 cycles with req=4'b1111 -> out_data stable, gnt=0; first cycle with out_ready=1 -> gnt=0100.
REQ-033 SHALL check drain: single capture, then req=0, out_ready=1 -> out_valid=0 the next cycle and state IDLE.
REQ-034 SHALL check reset mid-HOLD: reset high for one cycle -> out_valid=0, out_data=0, gnt=0; with req=4'b1010 next -> gnt=0010.
REQ-035 SHALL run 500 random cycles (random req, d0-d3, out_ready) against a reference model, checking gnt one-hot and fairness, out_data and out_valid every cycle, reporting FAIL with all values.
